// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer slice: channel state encoding,
// default sizing constants and a constant-evaluable ceil(log2) helper.
package timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_t;

   localparam int unsigned DEF_TICK_DIV  = 50000;
   localparam int unsigned DEF_CNT_WIDTH = 16;

   // Number of bits needed to hold values 0..value-1 (value >= 2).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned result;
      v      = value - 1;
      result = 0;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running shared prescaler: emits a registered 1-cycle base_tick each
// time the counter wraps from TICK_DIV-1 to 0; holds while enable is low.
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic base_tick
);

   localparam int unsigned PW = clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         base_tick <= 1'b0;
      end else begin
         base_tick <= 1'b0;
         if (enable) begin
            if (cnt == LAST) begin
               cnt       <= '0;
               base_tick <= 1'b1;
            end else begin
               cnt <= cnt + PW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/multi_channel_interval_timer.sv
// NUM_CH independent interval timers counting shared base ticks up to a
// latched limit, in one-shot or periodic mode, with 1-cycle timeout pulses.
module multi_channel_interval_timer
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
   parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int unsigned NUM_CH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [NUM_CH-1:0]             ch_start,
   input  logic [NUM_CH-1:0]             ch_stop,
   input  logic [NUM_CH-1:0]             ch_periodic,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   ch_limit,
   output logic                          base_tick,
   output logic [NUM_CH-1:0]             timeout_pulse,
   output logic [NUM_CH-1:0]             ch_busy,
   output logic [NUM_CH*CNT_WIDTH-1:0]   ch_count
);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .base_tick (base_tick)
   );

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_t            state;
      logic [CNT_WIDTH-1:0] count;
      logic [CNT_WIDTH-1:0] limit;
      logic [CNT_WIDTH-1:0] lim_in;
      logic                 periodic;
      logic                 pulse;

      assign lim_in = ch_limit[i*CNT_WIDTH +: CNT_WIDTH];

      // Priority: stop, then start/restart (swallows a coincident tick), then tick.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            limit    <= '0;
            periodic <= 1'b0;
            pulse    <= 1'b0;
         end else begin
            pulse <= 1'b0;
            if (ch_stop[i]) begin
               state <= IDLE;
               count <= '0;
            end else if (ch_start[i]) begin
               count <= '0;
               if (lim_in != '0) begin
                  state    <= RUN;
                  limit    <= lim_in;
                  periodic <= ch_periodic[i];
               end else begin
                  state <= IDLE;
               end
            end else if (state == RUN && base_tick) begin
               if (count == limit - CNT_WIDTH'(1)) begin
                  pulse <= 1'b1;
                  count <= '0;
                  if (!periodic) state <= IDLE;
               end else begin
                  count <= count + CNT_WIDTH'(1);
               end
            end
         end
      end

      assign timeout_pulse[i]                        = pulse;
      assign ch_busy[i]                              = (state == RUN);
      assign ch_count[i*CNT_WIDTH +: CNT_WIDTH]      = count;
   end

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Directed plus randomized bench for multi_channel_interval_timer against a
// tick-counting reference model (TICK_DIV=4, CNT_WIDTH=8, NUM_CH=2).
module tb_multi_channel_interval_timer;

   localparam int unsigned TD = 4;
   localparam int unsigned CW = 8;
   localparam int unsigned NC = 2;

   logic             clk;
   logic             rst;
   logic             enable;
   logic [NC-1:0]    ch_start;
   logic [NC-1:0]    ch_stop;
   logic [NC-1:0]    ch_periodic;
   logic [NC*CW-1:0] ch_limit;
   logic             base_tick;
   logic [NC-1:0]    timeout_pulse;
   logic [NC-1:0]    ch_busy;
   logic [NC*CW-1:0] ch_count;

   int unsigned tests_run;
   int unsigned tests_failed;

   multi_channel_interval_timer #(
      .TICK_DIV  (TD),
      .CNT_WIDTH (CW),
      .NUM_CH    (NC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .ch_start      (ch_start),
      .ch_stop       (ch_stop),
      .ch_periodic   (ch_periodic),
      .ch_limit      (ch_limit),
      .base_tick     (base_tick),
      .timeout_pulse (timeout_pulse),
      .ch_busy       (ch_busy),
      .ch_count      (ch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // Reference model: enabled-edge count for the prescaler, ticks-since-start per channel.
   int unsigned m_en_edges;
   bit          m_tick;
   bit          m_busy  [NC];
   int unsigned m_ticks [NC];
   int unsigned m_lim   [NC];
   bit          m_per   [NC];
   bit          m_pulse [NC];

   function automatic void model_reset();
      m_en_edges = 0;
      m_tick     = 1'b0;
      for (int c = 0; c < NC; c++) begin
         m_busy[c]  = 1'b0;
         m_ticks[c] = 0;
         m_lim[c]   = 0;
         m_per[c]   = 1'b0;
         m_pulse[c] = 1'b0;
      end
   endfunction

   function automatic void model_edge();
      bit          tick_now;
      int unsigned lim;
      tick_now = m_tick;
      for (int c = 0; c < NC; c++) begin
         m_pulse[c] = 1'b0;
         lim = ch_limit[c*CW +: CW];
         if (ch_stop[c]) begin
            m_busy[c]  = 1'b0;
            m_ticks[c] = 0;
         end else if (ch_start[c]) begin
            m_ticks[c] = 0;
            m_busy[c]  = (lim != 0);
            if (lim != 0) begin
               m_lim[c] = lim;
               m_per[c] = ch_periodic[c];
            end
         end else if (m_busy[c] && tick_now) begin
            m_ticks[c] = m_ticks[c] + 1;
            if (m_ticks[c] % m_lim[c] == 0) begin
               m_pulse[c] = 1'b1;
               if (!m_per[c]) m_busy[c] = 1'b0;
            end
         end
      end
      if (enable) begin
         m_en_edges = m_en_edges + 1;
         m_tick     = (m_en_edges % TD == 0);
      end else begin
         m_tick = 1'b0;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [NC-1:0]    ep;
      logic [NC-1:0]    eb;
      logic [NC*CW-1:0] ec;
      for (int c = 0; c < NC; c++) begin
         ep[c] = m_pulse[c];
         eb[c] = m_busy[c];
         ec[c*CW +: CW] = m_busy[c] ? CW'(m_ticks[c] % m_lim[c]) : '0;
      end
      chk("model_base_tick", 32'(base_tick), 32'(m_tick));
      chk("model_timeout", 32'(timeout_pulse), 32'(ep));
      chk("model_busy", 32'(ch_busy), 32'(eb));
      chk("model_count", 32'(ch_count), 32'(ec));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_ch(input int c, input int unsigned lim, input bit per);
      ch_limit[c*CW +: CW] = CW'(lim);
      ch_periodic[c]       = per;
   endtask

   task automatic sync_tick();
      bit found;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         cycle();
         if (base_tick) found = 1'b1;
      end
      chk("sync_tick_seen", 32'(found), 32'd1);
   endtask

   initial begin
      int unsigned np, tp, last, seen, maxc, t, t_a, t0, t1;
      bit          found, gap_ok, busy_ok, seq_ok, hold_ok, bt_ok;
      logic [NC-1:0] pat;
      logic [CW-1:0] prev;

      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;
      enable       = 1'b0;
      ch_start     = '0;
      ch_stop      = '0;
      ch_periodic  = '0;
      ch_limit     = '0;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      check_all();
      rst    = 1'b1;
      enable = 1'b1;

      // One-shot, limit 5
      set_ch(0, 5, 1'b0);
      ch_start[0] = 1'b1; cycle(); ch_start[0] = 1'b0;
      np = 0; tp = 0;
      for (int n = 1; n <= 30; n++) begin
         cycle();
         if (timeout_pulse[0]) begin
            np++;
            if (tp == 0) tp = n;
         end
      end
      chk("oneshot_npulse", np, 32'd1);
      chk("oneshot_window", 32'(tp >= 17 && tp <= 21), 32'd1);
      chk("oneshot_busy", 32'(ch_busy[0]), 32'd0);
      chk("oneshot_count", 32'(ch_count[CW-1:0]), 32'd0);

      // Periodic, ch1 limit 3
      set_ch(1, 3, 1'b1);
      ch_start[1] = 1'b1; cycle(); ch_start[1] = 1'b0;
      last = 0; seen = 0; maxc = 0;
      gap_ok = 1'b1; busy_ok = 1'b1; seq_ok = 1'b1;
      prev = ch_count[2*CW-1:CW];
      for (int n = 1; n <= 50; n++) begin
         cycle();
         if (!ch_busy[1]) busy_ok = 1'b0;
         if (ch_count[2*CW-1:CW] > CW'(maxc)) maxc = ch_count[2*CW-1:CW];
         if (ch_count[2*CW-1:CW] != prev) begin
            if (ch_count[2*CW-1:CW] != CW'((prev + 1) % 3)) seq_ok = 1'b0;
            prev = ch_count[2*CW-1:CW];
         end
         if (timeout_pulse[1]) begin
            if (seen > 0 && n - last != 12) gap_ok = 1'b0;
            seen++;
            last = n;
         end
      end
      chk("periodic_npulse", 32'(seen >= 3), 32'd1);
      chk("periodic_gap12", 32'(gap_ok), 32'd1);
      chk("periodic_busy", 32'(busy_ok), 32'd1);
      chk("periodic_maxcount", maxc, 32'd2);
      chk("periodic_sequence", 32'(seq_ok), 32'd1);
      ch_stop[1] = 1'b1; cycle(); ch_stop[1] = 1'b0;

      // Stop at count 4, start+stop together, restart on a base_tick
      set_ch(0, 10, 1'b0);
      ch_start[0] = 1'b1; cycle(); ch_start[0] = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         cycle();
         if (ch_count[CW-1:0] == 4) found = 1'b1;
      end
      chk("stop_reach4", 32'(found), 32'd1);
      ch_stop[0] = 1'b1; cycle(); ch_stop[0] = 1'b0;
      chk("stop_busy", 32'(ch_busy[0]), 32'd0);
      chk("stop_count", 32'(ch_count[CW-1:0]), 32'd0);
      np = 0;
      for (int n = 0; n < 50; n++) begin
         cycle();
         if (timeout_pulse[0]) np++;
      end
      chk("stop_nopulse", np, 32'd0);
      ch_start[0] = 1'b1; ch_stop[0] = 1'b1; cycle();
      ch_start[0] = 1'b0; ch_stop[0] = 1'b0;
      chk("startstop_idle", 32'(ch_busy[0]), 32'd0);
      set_ch(0, 3, 1'b1);
      ch_start[0] = 1'b1; cycle(); ch_start[0] = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         cycle();
         if (ch_count[CW-1:0] == 2 && base_tick) found = 1'b1;
      end
      chk("restart_align", 32'(found), 32'd1);
      ch_start[0] = 1'b1; cycle(); ch_start[0] = 1'b0;
      chk("restart_count", 32'(ch_count[CW-1:0]), 32'd0);
      chk("restart_nopulse", 32'(timeout_pulse[0]), 32'd0);
      chk("restart_busy", 32'(ch_busy[0]), 32'd1);
      ch_stop[0] = 1'b1; cycle(); ch_stop[0] = 1'b0;

      // Enable freeze: reference run, then the same run frozen 20 clocks at count 2
      sync_tick();
      set_ch(0, 5, 1'b0);
      ch_start[0] = 1'b1; cycle(); ch_start[0] = 1'b0;
      t_a = 0;
      for (int n = 1; n <= 40 && t_a == 0; n++) begin
         cycle();
         if (timeout_pulse[0]) t_a = n;
      end
      chk("freeze_reference", t_a, 32'd20);
      sync_tick();
      ch_start[0] = 1'b1; cycle(); ch_start[0] = 1'b0;
      t = 0; found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         cycle(); t++;
         if (ch_count[CW-1:0] == 2) found = 1'b1;
      end
      chk("freeze_reach2", 32'(found), 32'd1);
      enable = 1'b0; hold_ok = 1'b1; bt_ok = 1'b1;
      for (int n = 0; n < 20; n++) begin
         cycle(); t++;
         if (ch_count[CW-1:0] != 2) hold_ok = 1'b0;
         if (base_tick) bt_ok = 1'b0;
      end
      enable = 1'b1;
      chk("freeze_hold", 32'(hold_ok), 32'd1);
      chk("freeze_no_tick", 32'(bt_ok), 32'd1);
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         cycle(); t++;
         if (timeout_pulse[0]) found = 1'b1;
      end
      chk("freeze_pulse_seen", 32'(found), 32'd1);
      chk("freeze_delay", t - t_a, 32'd20);

      // Limit 0 ignored, limit 1 periodic, coincident limit 2
      set_ch(0, 0, 1'b0);
      ch_start[0] = 1'b1; cycle(); ch_start[0] = 1'b0;
      chk("limit0_busy", 32'(ch_busy[0]), 32'd0);
      set_ch(0, 1, 1'b1);
      ch_start[0] = 1'b1; cycle(); ch_start[0] = 1'b0;
      last = 0; seen = 0; gap_ok = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         cycle();
         if (timeout_pulse[0]) begin
            if (seen > 0 && n - last != TD) gap_ok = 1'b0;
            seen++;
            last = n;
         end
      end
      chk("limit1_npulse", 32'(seen >= 6), 32'd1);
      chk("limit1_gap4", 32'(gap_ok), 32'd1);
      ch_stop[0] = 1'b1; cycle(); ch_stop[0] = 1'b0;
      set_ch(0, 2, 1'b0);
      set_ch(1, 2, 1'b0);
      ch_start = '1; cycle(); ch_start = '0;
      pat = '0; t0 = 0;
      for (int n = 1; n <= 20 && t0 == 0; n++) begin
         cycle();
         if (timeout_pulse != '0) begin
            pat = timeout_pulse;
            t0  = n;
         end
      end
      chk("coincident_pulses", 32'(pat), 32'h3);

      // Asynchronous reset mid-count
      set_ch(0, 10, 1'b0);
      ch_start[0] = 1'b1; cycle(); ch_start[0] = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         cycle();
         if (ch_count[CW-1:0] == 3) found = 1'b1;
      end
      chk("reset_reach3", 32'(found), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("reset_async_count", 32'(ch_count), 32'd0);
      chk("reset_async_busy", 32'(ch_busy), 32'd0);
      chk("reset_async_pulse", 32'(timeout_pulse), 32'd0);
      chk("reset_async_tick", 32'(base_tick), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      np = 0;
      for (int n = 0; n < 60; n++) begin
         cycle();
         if (timeout_pulse != '0) np++;
      end
      chk("reset_nopulse", np, 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         enable = ($urandom_range(0, 9) != 0);
         for (int c = 0; c < NC; c++) begin
            ch_start[c] = ($urandom_range(0, 15) == 0);
            ch_stop[c]  = ($urandom_range(0, 40) == 0);
            set_ch(c, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
         end
         cycle();
      end
      t1 = tests_run;
      chk("random_ran", 32'(t1 > 1000), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/multi_channel_interval_timer.md
Name: multi_channel_interval_timer

Overview:
- Parametrised successor to the fixed single-channel 100 ms timer.
- One shared prescaler generates a base tick every TICK_DIV clocks. NUM_CH independent channels each count base ticks up to a per-channel programmable limit.
- Each channel runs in one-shot or periodic mode and emits a 1-cycle timeout pulse.
- Sits between game-control logic and the LED/asteroid timing consumers, replacing chains of hard-coded timers.

Parameters:
- TICK_DIV, 50000, clocks per base tick (1 ms at 50 MHz); legal range >= 2.
- CNT_WIDTH, 16, width of the per-channel tick counter and limit.
- NUM_CH, 4, number of independent channels; legal range >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  global run enable; 0 freezes prescaler and all channel counters.
- ch_start  in  NUM_CH  per-channel start/restart request, sampled each clock.
- ch_stop  in  NUM_CH  per-channel abort request.
- ch_periodic  in  NUM_CH  mode, latched at start; 1 = auto-reload, 0 = one-shot.
- ch_limit  in  NUM_CH*CNT_WIDTH  per-channel tick count, latched at start; channel i uses bits [i*CNT_WIDTH +: CNT_WIDTH].
- base_tick  out  1  registered 1-cycle pulse per prescaler wrap.
- timeout_pulse  out  NUM_CH  registered 1-cycle pulse when a channel reaches its limit.
- ch_busy  out  NUM_CH  1 while the channel is in RUN.
- ch_count  out  NUM_CH*CNT_WIDTH  current tick count per channel.

Behaviour:
- Reset (rst=0, asynchronous) clears the following to 0: the prescaler, base_tick, every timeout_pulse bit, ch_busy, ch_count, latched limits and latched modes. All channels go to IDLE. This also applies mid-count; no pulse is emitted on reset release.
- Prescaler counts 0..TICK_DIV-1 while enable=1.
  - On the edge where it wraps from TICK_DIV-1 to 0, base_tick=1 for exactly one cycle.
  - With enable=0 the prescaler holds its value and base_tick is 0.
- The prescaler is free-running and shared. The first channel timeout after start therefore occurs between (N-1)*TICK_DIV+1 and N*TICK_DIV+1 clocks after the start edge, for limit N. Later periodic timeouts are exactly N*TICK_DIV clocks apart.
- Channel FSM, states IDLE and RUN:
  - IDLE, ch_start=1 and ch_limit!=0: latch limit and mode, count<=0, go to RUN.
  - IDLE, ch_start=1 and ch_limit==0: ignored; channel stays IDLE with no pulse.
  - RUN, base_tick=1, count<limit-1: count<=count+1.
  - RUN, base_tick=1, count==limit-1: timeout_pulse[i]<=1 for one cycle.
    - Periodic: count<=0, stay in RUN.
    - One-shot: count<=0, go to IDLE.
  - RUN, ch_start=1: restart. Relatch limit and mode, count<=0. Any coincident base_tick is ignored and no pulse is emitted. ch_limit==0 on restart stops the channel and returns it to IDLE.
  - ch_stop=1 in any state: go to IDLE, count<=0, no pulse.
- Priority per channel, highest first: rst, ch_stop, ch_start, base_tick.
- enable=0 blocks base_tick, so channels hold count and state. Start and stop are still honoured.
- Limit == 1 with periodic mode gives one pulse per base tick.
- Count arithmetic is unsigned CNT_WIDTH. The count never exceeds limit-1, so it cannot overflow.
- Channels are fully independent. Simultaneous timeouts on several channels all assert in the same cycle.

Decomposition:
- Shared package timer_pkg holds:
  - the channel state encoding (IDLE=1'b0, RUN=1'b1);
  - default constants DEF_TICK_DIV=50000 and DEF_CNT_WIDTH=16;
  - a helper function clog2 for sizing the prescaler as clog2(TICK_DIV) bits.
- One natural sub-module: tick_prescaler, with clk, rst, enable and base_tick and parameter TICK_DIV.
- Channel logic is a generate loop over NUM_CH in the top module.

Test Plan:
All scenarios use TICK_DIV=4, CNT_WIDTH=8, NUM_CH=2.
- Reset: assert rst=0 mid-run with ch0 count=3. All outputs go to 0 immediately, without waiting for a clock edge. After release, no timeout occurs until a new start.
- One-shot: ch0 limit=5, periodic=0, start pulsed. Exactly one timeout_pulse[0] occurs within 17..21 clocks, then ch_busy[0]=0 and ch_count[0]=0.
- Periodic: ch1 limit=3, periodic=1. Pulses repeat every 12 clocks, ch_busy[1] stays 1, and ch_count[1] cycles 0,1,2.
- Stop/restart: ch0 limit=10; issue ch_stop at count 4 and check no pulse. Then raise ch_start and ch_stop together and check the channel stays IDLE. Then restart on the same cycle as a base_tick and check count=0 and no pulse.
- Enable freeze: deassert enable for 20 clocks at ch0 count=2. The count holds at 2 and base_tick stays 0. The timeout is delayed by exactly 20 clocks.
- Limit edge cases: limit=0 start is ignored (busy stays 0). Limit=1 periodic gives a pulse every 4 clocks. Both channels with limit=2, started on the same cycle, produce coincident pulses.
